zl_uart_regbank: RTL and testbench
==================================

Name: zl_uart_regbank

Overview:
- Parametrised successor to the single-register UART access block: a UART-to-register-bank bridge with a configurable baud divisor and register count.
- Uses standard 8N1 framing (LSB-first, stop-bit check) with mid-bit sampling, instead of one-sample-per-clock MSB-first framing.
- Sits behind the TinyTapeout io_in/io_out wrapper. Host reads two signature bytes and reads/writes NUM_REGS general registers, exported as a flat bus for LEDs and other logic.
- Adds a write-data timeout and a framing-error report.

Parameters:
- CLKS_PER_BIT, 4: clk cycles per UART bit; legal range 4..255, even.
- NUM_REGS, 4: number of RW registers; legal range 1..126.
- SIGNATURE, 16'hDEDA: read-only ID bytes.
- REG_RESET, 8'h49: reset value of every RW register.
- TIMEOUT_BITS, 16: bit periods to wait for a write-data start bit.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx  in  1  UART receive, idle high, asynchronous to clk
- tx  out  1  UART transmit, idle high
- regs_out  out  NUM_REGS*8  register r occupies bits [8r+7:8r]
- busy  out  1  high whenever FSM is not IDLE
- frame_err  out  1  one-cycle pulse on bad stop bit or false start
- timeout  out  1  one-cycle pulse on write-data timeout

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: tx=1, busy=0, frame_err=0, timeout=0, all regs=REG_RESET, rx synchroniser=2'b11, FSM=IDLE. Reset mid-frame aborts everything; tx is 1 after the next edge.
- rx passes a 2-flop synchroniser; all sampling uses the synchronised value rxs.
- Byte receive (shared by command and data):
  - Falling edge of rxs starts a byte. Wait CLKS_PER_BIT/2 cycles, then resample.
  - If rxs=1 at that point: false start, frame_err pulse, return to caller's wait state.
  - Otherwise sample 8 data bits LSB-first every CLKS_PER_BIT cycles, then the stop bit.
  - Stop bit=0: frame_err pulse, byte discarded, go to IDLE after rxs=1.
- Command byte: bit0 = write flag; bits[7:1] = index.
  - Index 0 returns SIGNATURE[15:8]; index 1 returns SIGNATURE[7:0].
  - Index 2..NUM_REGS+1 maps to reg (index-2).
  - Other indices read 8'h00; writes to them are ignored, including writes to indices 0 and 1.
- States:
  - IDLE -> RX_CMD on falling edge of rxs.
  - RX_CMD -> TX_TURN on a good read command.
  - RX_CMD -> WAIT_WDATA on a good write command.
  - TX_TURN: the read value is snapshotted on the command stop-sample cycle. Hold tx=1 for CLKS_PER_BIT cycles -> TX_DATA.
  - TX_DATA: start bit 0, 8 data bits LSB-first, stop bit 1, each CLKS_PER_BIT cycles -> IDLE. rx is ignored during TX.
  - WAIT_WDATA: count up to TIMEOUT_BITS*CLKS_PER_BIT cycles. Falling edge -> RX_WDATA. Expiry -> timeout pulse, IDLE, no write.
  - RX_WDATA: on good stop bit, write the register on the stop-sample cycle; regs_out shows the new value the next cycle -> IDLE.
- Error recovery: after any error the FSM waits in IDLE until rxs=1 before accepting a new start, so no false retrigger on a stuck-low line.
- Counters: bit-timer width is clog2(CLKS_PER_BIT); timeout counter width is clog2(TIMEOUT_BITS*CLKS_PER_BIT+1). No wrap is permitted.
- Reset and a start edge in the same cycle: reset wins.

Decomposition:
- Package zl_uart_pkg holds the FSM state encoding, the index constants (IDX_SIG_HI=0, IDX_SIG_LO=1, IDX_REG_BASE=2) and the write-flag bit position.
- Sub-module zl_uart_rx_byte (CLKS_PER_BIT):
  - Inputs: rxs, enable.
  - Outputs: valid pulse, data[7:0], ferr pulse.
  - Instantiated once and reused for command and data bytes.
- TX shifter and timeout counter stay in the top level.

Test Plan (CLKS_PER_BIT=4, NUM_REGS=4, TIMEOUT_BITS=16):
- Send 0x00, then 0x02 -> tx returns 0xDE, then 0xDA. Each start bit begins exactly 4 cycles after the command stop-sample; busy=0 after the stop bit.
- Send 0x05, 0xA5 -> regs_out[7:0]=0xA5 one cycle after the data stop-sample. Then send 0x04 -> tx returns 0xA5; regs_out[31:8] stay 0x494949.
- Send 0x0B (write reg3) and no data for 64 cycles -> single timeout pulse at cycle 64, regs unchanged, busy=0.
- Send 0x05 with stop bit 0 -> frame_err pulse, no write. Hold rx low 1 cycle (glitch) -> frame_err pulse, no frame, tx stays 1.
- Send 0x14 (read index 10) -> tx returns 0x00. Send 0x15, 0xFF, then 0x01, 0x00 -> no register changes.
- Assert reset during TX_DATA bit 3 -> next cycle tx=1, busy=0, all regs=0x49. A following 0x00 read returns 0xDE.

Source files
------------

// File: rtl/zl_uart_pkg.sv
// zl_uart_pkg: shared FSM encoding and command field constants for the UART register bridge
package zl_uart_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_CMD,
    S_TX_TURN,
    S_TX_DATA,
    S_WAIT_WDATA,
    S_RX_WDATA
  } state_t;
  localparam int IDX_SIG_HI = 0;
  localparam int IDX_SIG_LO = 1;
  localparam int IDX_REG_BASE = 2;
  localparam int WR_BIT = 0;
  localparam logic [3:0] STOP_BIT = 4'd9;
endpackage

// File: rtl/zl_uart_rx_byte.sv
// zl_uart_rx_byte: 8N1 byte receiver with mid-bit sampling, armed by the caller one cycle after the start edge
module zl_uart_rx_byte
  import zl_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxs,
  input  logic       enable,
  output logic       valid,
  output logic [7:0] data,
  output logic       ferr
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [7:0]    r_data;
  logic          w_tick;
  logic          w_shift;
  // the start bit is judged half a bit in; every later bit a full bit after the previous sample
  always_comb begin
    w_tick  = enable & (r_cnt == ((r_bit == 4'd0) ? CW'(CLKS_PER_BIT/2-1) : CW'(CLKS_PER_BIT-1)));
    w_shift = w_tick & (r_bit != 4'd0) & (r_bit != STOP_BIT);
    valid   = w_tick & (r_bit == STOP_BIT) & rxs;
    ferr    = w_tick & (((r_bit == 4'd0) & rxs) | ((r_bit == STOP_BIT) & ~rxs));
    data    = r_data;
  end
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      r_cnt <= '0;
      r_bit <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      r_bit <= r_bit + {3'd0, w_tick};
    end
    if (reset) r_data <= '0;
    else if (w_shift) r_data <= {rxs, r_data[7:1]};
  end
endmodule

// File: rtl/zl_uart_regbank.sv
// zl_uart_regbank: UART-to-register-bank bridge; command byte {index, write}, reads answer one byte,
// writes take a following data byte with a timeout.
module zl_uart_regbank
  import zl_uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 4,
  parameter int          NUM_REGS     = 4,
  parameter logic [15:0] SIGNATURE    = 16'hDEDA,
  parameter logic [7:0]  REG_RESET    = 8'h49,
  parameter int          TIMEOUT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic                  tx,
  output logic [NUM_REGS*8-1:0] regs_out,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  timeout
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TL = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TL + 1);
  state_t        r_state, w_next;
  logic [1:0]    r_sync;
  logic          r_rxs_d;
  logic          w_rxs, w_fall, w_en, w_valid, w_ferr, w_expire, w_bit_end;
  logic [7:0]    w_data, w_rd;
  logic [6:0]    w_idx, r_widx;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [9:0]    r_frame;
  logic [TW-1:0] r_to;
  logic [7:0]    r_regs [NUM_REGS];
  assign w_rxs     = r_sync[1];
  assign w_fall    = r_rxs_d & ~w_rxs;
  assign w_idx     = w_data[7:1];
  assign w_bit_end = r_cnt == CW'(CLKS_PER_BIT-1);
  assign w_expire  = (r_state == S_WAIT_WDATA) & (r_to == TW'(TL-1));
  // a stuck-low line never produces another fall, so errors cannot retrigger until rxs returns high
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= 2'b11;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync  <= {r_sync[0], rx};
      r_rxs_d <= w_rxs;
    end
  end
  zl_uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk   (clk),
    .reset (reset),
    .rxs   (w_rxs),
    .enable(w_en),
    .valid (w_valid),
    .data  (w_data),
    .ferr  (w_ferr)
  );
  always_comb begin
    w_rd = 8'h00;
    if (int'(w_idx) == IDX_SIG_HI) w_rd = SIGNATURE[15:8];
    if (int'(w_idx) == IDX_SIG_LO) w_rd = SIGNATURE[7:0];
    for (int r = 0; r < NUM_REGS; r++)
      if (int'(w_idx) == IDX_REG_BASE + r) w_rd = r_regs[r];
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // a false start inside a write returns to the data wait; a bad stop bit abandons the transaction
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (w_fall) w_next = S_RX_CMD;
      S_RX_CMD:     if (w_ferr) w_next = S_IDLE;
                    else if (w_valid) w_next = w_data[WR_BIT] ? S_WAIT_WDATA : S_TX_TURN;
      S_TX_TURN:    if (r_cnt == CW'(CLKS_PER_BIT-2)) w_next = S_TX_DATA;
      S_TX_DATA:    if (w_bit_end && r_bit == STOP_BIT) w_next = S_IDLE;
      S_WAIT_WDATA: if (w_fall) w_next = S_RX_WDATA;
                    else if (w_expire) w_next = S_IDLE;
      S_RX_WDATA:   if (w_ferr) w_next = w_rxs ? S_WAIT_WDATA : S_IDLE;
                    else if (w_valid) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end
  always_comb begin
    busy      = r_state != S_IDLE;
    tx        = (r_state == S_TX_DATA) ? r_frame[0] : 1'b1;
    w_en      = (r_state == S_RX_CMD) | (r_state == S_RX_WDATA);
    frame_err = w_ferr;
    timeout   = w_expire & ~w_fall;
  end
  // the turnaround is CLKS_PER_BIT-1 cycles so that, with the stop-sample cycle, tx idles one full bit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_frame <= '1;
      r_to    <= '0;
      r_widx  <= '0;
    end else begin
      r_cnt <= (w_next == r_state && (r_state == S_TX_TURN || r_state == S_TX_DATA) && !w_bit_end) ? r_cnt + 1'b1 : '0;
      r_bit <= (r_state != S_TX_DATA) ? '0 : w_bit_end ? r_bit + 1'b1 : r_bit;
      r_to  <= (r_state == S_WAIT_WDATA) ? r_to + 1'b1 : (r_state == S_RX_WDATA) ? r_to : '0;
      if (r_state == S_RX_CMD && w_valid) begin
        r_frame <= {1'b1, w_rd, 1'b0};
        r_widx  <= w_idx;
      end else if (r_state == S_TX_DATA && w_bit_end) begin
        r_frame <= {1'b1, r_frame[9:1]};
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++)
      if (reset) r_regs[r] <= REG_RESET;
      else if (r_state == S_RX_WDATA && w_valid && int'(r_widx) == IDX_REG_BASE + r) r_regs[r] <= w_data;
  end
  genvar g;
  for (g = 0; g < NUM_REGS; g++) begin : g_out
    assign regs_out[8*g +: 8] = r_regs[g];
  end
endmodule

// File: tb/tb_zl_uart_regbank.sv
// tb_zl_uart_regbank: directed scenarios for the UART register bridge at 4 clocks per bit
module tb_zl_uart_regbank;
  localparam int C = 4;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        tx, busy, frame_err, timeout;
  logic [31:0] regs_out;
  int          n_checks = 0;
  int          n_errors = 0;

  zl_uart_regbank #(.CLKS_PER_BIT(C), .NUM_REGS(4), .TIMEOUT_BITS(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .tx       (tx),
    .regs_out (regs_out),
    .busy     (busy),
    .frame_err(frame_err),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // called on a negedge; returns on the negedge inside the DUT's stop-sample cycle
  task automatic send_frame(input logic [7:0] b, input logic stop);
    for (int j = 0; j < 10; j++) begin
      rx = (j == 0) ? 1'b0 : (j == 9) ? stop : b[j-1];
      repeat (C) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  // called in the stop-sample cycle of a read command; captures the answer frame
  task automatic capture_tx(output logic [7:0] got, output logic start_ok, output logic stop_bit, output logic busy_after);
    start_ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (tx !== 1'b1) start_ok = 1'b0;
    end
    @(negedge clk);
    if (tx !== 1'b0) start_ok = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      repeat (C) @(negedge clk);
      got[k] = tx;
    end
    repeat (C) @(negedge clk);
    stop_bit = tx;
    repeat (2) @(negedge clk);
    busy_after = busy;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 5;
    if (tx !== 1'b1) begin n_errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
    if (timeout !== 1'b0) begin n_errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    if (regs_out !== 32'h49494949) begin n_errors++; $display("FAIL reset_regs: got %h expected 49494949", regs_out); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_signature;
    logic [7:0] got;
    logic       st, sp, ba;
    send_frame(8'h00, 1'b1);
    capture_tx(got, st, sp, ba);
    n_checks += 4;
    if (got !== 8'hDE) begin n_errors++; $display("FAIL sig_hi: got %h expected de", got); end
    if (st !== 1'b1) begin n_errors++; $display("FAIL sig_hi_start: got %b expected 1", st); end
    if (sp !== 1'b1) begin n_errors++; $display("FAIL sig_hi_stop: got %b expected 1", sp); end
    if (ba !== 1'b0) begin n_errors++; $display("FAIL sig_hi_busy: got %b expected 0", ba); end
    send_frame(8'h02, 1'b1);
    capture_tx(got, st, sp, ba);
    n_checks += 3;
    if (got !== 8'hDA) begin n_errors++; $display("FAIL sig_lo: got %h expected da", got); end
    if (st !== 1'b1) begin n_errors++; $display("FAIL sig_lo_start: got %b expected 1", st); end
    if (ba !== 1'b0) begin n_errors++; $display("FAIL sig_lo_busy: got %b expected 0", ba); end
  endtask

  task automatic test_write_read;
    logic [7:0] got;
    logic       st, sp, ba;
    send_frame(8'h05, 1'b1);
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL wr_cmd_busy: got %b expected 1", busy); end
    send_frame(8'hA5, 1'b1);
    n_checks++;
    if (regs_out[7:0] !== 8'h49) begin n_errors++; $display("FAIL wr_early: got %h expected 49", regs_out[7:0]); end
    @(negedge clk);
    n_checks += 2;
    if (regs_out[7:0] !== 8'hA5) begin n_errors++; $display("FAIL wr_reg0: got %h expected a5", regs_out[7:0]); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL wr_busy: got %b expected 0", busy); end
    send_frame(8'h04, 1'b1);
    capture_tx(got, st, sp, ba);
    n_checks += 3;
    if (got !== 8'hA5) begin n_errors++; $display("FAIL rd_reg0: got %h expected a5", got); end
    if (st !== 1'b1) begin n_errors++; $display("FAIL rd_reg0_start: got %b expected 1", st); end
    if (regs_out[31:8] !== 24'h494949) begin n_errors++; $display("FAIL wr_others: got %h expected 494949", regs_out[31:8]); end
  endtask

  task automatic test_timeout;
    int first = 0;
    int pulses = 0;
    send_frame(8'h0B, 1'b1);
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    n_checks += 4;
    if (first != 64) begin n_errors++; $display("FAIL to_cycle: got %0d expected 64", first); end
    if (pulses != 1) begin n_errors++; $display("FAIL to_pulses: got %0d expected 1", pulses); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL to_busy: got %b expected 0", busy); end
    if (regs_out !== 32'h494949A5) begin n_errors++; $display("FAIL to_regs: got %h expected 494949a5", regs_out); end
  endtask

  task automatic test_frame_err;
    int tx_low = 0;
    send_frame(8'h05, 1'b0);
    n_checks++;
    if (frame_err !== 1'b1) begin n_errors++; $display("FAIL ferr_stop: got %b expected 1", frame_err); end
    @(negedge clk);
    n_checks += 2;
    if (frame_err !== 1'b0) begin n_errors++; $display("FAIL ferr_width: got %b expected 0", frame_err); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL ferr_busy: got %b expected 0", busy); end
    repeat (100) @(negedge clk);
    n_checks += 2;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL ferr_idle: got %b expected 0", busy); end
    if (regs_out !== 32'h494949A5) begin n_errors++; $display("FAIL ferr_regs: got %h expected 494949a5", regs_out); end
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low++;
    end
    n_checks += 2;
    if (frame_err !== 1'b1) begin n_errors++; $display("FAIL glitch_ferr: got %b expected 1", frame_err); end
    if (busy !== 1'b1) begin n_errors++; $display("FAIL glitch_busy: got %b expected 1", busy); end
    repeat (2) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low++;
    end
    n_checks += 3;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL glitch_idle: got %b expected 0", busy); end
    if (frame_err !== 1'b0) begin n_errors++; $display("FAIL glitch_ferr_end: got %b expected 0", frame_err); end
    if (tx_low != 0) begin n_errors++; $display("FAIL glitch_tx: got %0d low cycles expected 0", tx_low); end
  endtask

  task automatic test_unmapped;
    logic [7:0] got;
    logic       st, sp, ba;
    send_frame(8'h14, 1'b1);
    capture_tx(got, st, sp, ba);
    n_checks += 2;
    if (got !== 8'h00) begin n_errors++; $display("FAIL rd_idx10: got %h expected 00", got); end
    if (ba !== 1'b0) begin n_errors++; $display("FAIL rd_idx10_busy: got %b expected 0", ba); end
    send_frame(8'h15, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (2) @(negedge clk);
    send_frame(8'h01, 1'b1);
    send_frame(8'h00, 1'b1);
    repeat (2) @(negedge clk);
    n_checks += 2;
    if (regs_out !== 32'h494949A5) begin n_errors++; $display("FAIL wr_ignored: got %h expected 494949a5", regs_out); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL wr_ignored_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid_tx;
    logic [7:0] got;
    logic       st, sp, ba;
    send_frame(8'h00, 1'b1);
    repeat (21) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL mid_tx_busy: got %b expected 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    n_checks += 3;
    if (tx !== 1'b1) begin n_errors++; $display("FAIL mid_rst_tx: got %b expected 1", tx); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    if (regs_out !== 32'h49494949) begin n_errors++; $display("FAIL mid_rst_regs: got %h expected 49494949", regs_out); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    send_frame(8'h00, 1'b1);
    capture_tx(got, st, sp, ba);
    n_checks += 2;
    if (got !== 8'hDE) begin n_errors++; $display("FAIL post_rst_sig: got %h expected de", got); end
    if (st !== 1'b1) begin n_errors++; $display("FAIL post_rst_start: got %b expected 1", st); end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_signature;
    test_write_read;
    test_timeout;
    test_frame_err;
    test_unmapped;
    test_reset_mid_tx;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
